// File: rtl/mat_partial_accum.sv
// rtl/mat_partial_accum.sv - accumulates DIM*DIM partial-product sets and drains the saturated matrix
module mat_partial_accum #(
  parameter int DIM   = 3,
  parameter int ACC_W = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clk_e,
  input  logic [7:0] i_in_data,
  input  logic       i_in_valid,
  input  logic       i_in_last,
  output logic       o_in_ready,
  output logic [7:0] o_out_data,
  output logic       o_out_valid,
  output logic       o_out_last,
  input  logic       i_out_ready,
  output logic       o_err
);

  localparam int NE    = DIM * DIM;
  localparam int IDX_W = $clog2(NE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NE - 1);
  localparam logic signed [ACC_W-1:0] MAX8 = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] MIN8 = ACC_W'(-128);

  typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q [NE];
  logic signed [ACC_W-1:0] acc_d [NE];
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    err_q, err_d;
  logic signed [ACC_W-1:0] sel_acc;
  logic                    load_out;
  logic                    beat;
  logic                    hs;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [7:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-7){b[7]}}, b};
    if (s[ACC_W] != s[ACC_W-1])
      sat_acc = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_acc = s[ACC_W-1:0];
  endfunction

  function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] a);
    if (a > MAX8)
      sat8 = 8'h7F;
    else if (a < MIN8)
      sat8 = 8'h80;
    else
      sat8 = a[7:0];
  endfunction

  // The producer ignores back-pressure: every valid enabled cycle in ACCUM is a beat.
  assign beat = i_clk_e && i_in_valid && (state_q == ST_ACCUM);
  assign hs   = i_clk_e && out_valid_q && i_out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    load_out    = 1'b0;

    if (beat) begin
      for (int e = 0; e < NE; e++) begin
        if (idx_q == IDX_W'(e))
          acc_d[e] = sat_acc(acc_q[e], i_in_data);
      end
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (i_in_last) begin
        if (idx_q != IDX_LAST)
          err_d = 1'b1;
        idx_d    = '0;
        state_d  = ST_DRAIN;
        load_out = 1'b1;
      end
    end

    if (state_q == ST_DRAIN) begin
      if (i_clk_e && i_in_valid)
        err_d = 1'b1;
      if (hs) begin
        if (idx_q == IDX_LAST) begin
          for (int e = 0; e < NE; e++)
            acc_d[e] = '0;
          idx_d       = '0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_data_d  = '0;
          state_d     = ST_ACCUM;
        end else begin
          idx_d    = idx_q + 1'b1;
          load_out = 1'b1;
        end
      end
    end

    // Output element is taken from the post-update sums so the final beat is included.
    sel_acc = '0;
    for (int e = 0; e < NE; e++) begin
      if (idx_d == IDX_W'(e))
        sel_acc = acc_d[e];
    end
    if (load_out) begin
      out_valid_d = 1'b1;
      out_data_d  = sat8(sel_acc);
      out_last_d  = (idx_d == IDX_LAST);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_ACCUM;
      idx_q       <= '0;
      for (int e = 0; e < NE; e++)
        acc_q[e] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      for (int e = 0; e < NE; e++)
        acc_q[e] <= acc_d[e];
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign o_in_ready  = (state_q == ST_ACCUM);
  assign o_out_data  = out_data_q;
  assign o_out_valid = out_valid_q;
  assign o_out_last  = out_last_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_mat_partial_accum.sv
// tb/tb_mat_partial_accum.sv - randomized self-checking bench for mat_partial_accum
module tb_mat_partial_accum;

  localparam int DIM   = 3;
  localparam int NE    = DIM * DIM;
  localparam int ACC_W = 10;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_clk_e;
  logic [7:0] i_in_data;
  logic       i_in_valid;
  logic       i_in_last;
  logic       o_in_ready;
  logic [7:0] o_out_data;
  logic       o_out_valid;
  logic       o_out_last;
  logic       i_out_ready;
  logic       o_err;

  int checks = 0;
  int errors = 0;

  int         sums [NE];
  bit         model_err;
  logic [7:0] beat_q [$];

  mat_partial_accum #(.DIM(DIM), .ACC_W(ACC_W)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_clk_e     (i_clk_e),
    .i_in_data   (i_in_data),
    .i_in_valid  (i_in_valid),
    .i_in_last   (i_in_last),
    .o_in_ready  (o_in_ready),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .o_out_last  (o_out_last),
    .i_out_ready (i_out_ready),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_acc(input int v);
    int lim;
    lim = 1 << (ACC_W - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic int exp8(input int e);
    int s;
    s = sums[e];
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s & 255;
  endfunction

  task automatic clear_model();
    for (int e = 0; e < NE; e++) sums[e] = 0;
  endtask

  // Drive beat_q as one frame (last on the final beat); optional idle/disabled cycles between beats.
  task automatic send_frame(input bit gaps);
    int n;
    n = beat_q.size();
    for (int b = 0; b < n; b++) begin
      for (int g = 0; g < 2 && gaps && $urandom_range(0, 2) == 0; g++) begin
        if ($urandom_range(0, 1) == 1) begin
          i_clk_e = 1'b0; i_in_valid = 1'b1;
        end else begin
          i_clk_e = 1'b1; i_in_valid = 1'b0;
        end
        i_in_data = 8'($urandom_range(0, 255));
        i_in_last = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_ready", int'(o_in_ready), 1);
      end
      i_clk_e    = 1'b1;
      i_in_valid = 1'b1;
      i_in_data  = beat_q[b];
      i_in_last  = (b == n - 1);
      sums[b % NE] = clamp_acc(sums[b % NE] + int'($signed(beat_q[b])));
      @(negedge clk);
      if (b != n - 1) chk("beat_ready", int'(o_in_ready), 1);
    end
    if (n % NE != 0) model_err = 1'b1;
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
  endtask

  // mode 0: always ready; 1: ready low 5 cycles at element 4 with clk_e 1,0,1,0,1; 2: random
  task automatic drain(input int mode, input bit pulse, input int rst_at);
    int  e;
    int  cyc;
    int  stall;
    bit  pulsed;
    e = 0; cyc = 0; stall = 0; pulsed = 1'b0;
    for (int k = 0; k < NE; k++)
      chk("acc_sum", int'($signed(dut.acc_q[k])), sums[k]);
    while (e < NE && cyc < 400) begin
      cyc++;
      chk("out_valid", int'(o_out_valid), 1);
      chk("out_data", int'(o_out_data), exp8(e));
      chk("out_last", int'(o_out_last), (e == NE - 1) ? 1 : 0);
      chk("drain_ready", int'(o_in_ready), 0);
      if (e == rst_at) begin
        #2 i_rst = 1'b1;
        #1;
        chk("rst_valid", int'(o_out_valid), 0);
        chk("rst_last", int'(o_out_last), 0);
        chk("rst_err", int'(o_err), 0);
        @(negedge clk);
        i_rst = 1'b0;
        clear_model();
        model_err = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(o_in_ready), 1);
        chk("rst_valid2", int'(o_out_valid), 0);
        return;
      end
      i_in_valid = 1'b0;
      if (mode == 1) begin
        if (e == 4 && stall < 5) begin
          i_out_ready = 1'b0;
          i_clk_e     = (stall % 2 == 0);
          stall++;
        end else begin
          i_out_ready = 1'b1;
          i_clk_e     = 1'b1;
        end
      end else if (mode == 2) begin
        i_out_ready = ($urandom_range(0, 3) != 0);
        i_clk_e     = ($urandom_range(0, 4) != 0);
      end else begin
        i_out_ready = 1'b1;
        i_clk_e     = 1'b1;
      end
      if (pulse && e == 2 && !pulsed) begin
        i_in_valid = 1'b1;
        i_clk_e    = 1'b1;
        pulsed     = 1'b1;
        model_err  = 1'b1;
      end
      if (i_out_ready && i_clk_e) e++;
      @(negedge clk);
    end
    chk("drain_done", e, NE);
    i_in_valid  = 1'b0;
    i_clk_e     = 1'b1;
    i_out_ready = 1'b1;
    chk("end_valid", int'(o_out_valid), 0);
    chk("end_last", int'(o_out_last), 0);
    chk("end_ready", int'(o_in_ready), 1);
    chk("err", int'(o_err), int'(model_err));
    clear_model();
  endtask

  task automatic fill_const(input int n, input logic [7:0] v);
    beat_q.delete();
    for (int b = 0; b < n; b++) beat_q.push_back(v);
  endtask

  task automatic fill_rand(input int n);
    beat_q.delete();
    for (int b = 0; b < n; b++) beat_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_clk_e = 1'b1; i_in_data = '0; i_in_valid = 1'b0;
    i_in_last = 1'b0; i_out_ready = 1'b1;
    clear_model();
    model_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_valid", int'(o_out_valid), 0);
    chk("reset_last", int'(o_out_last), 0);
    chk("reset_data", int'(o_out_data), 0);
    chk("reset_err", int'(o_err), 0);
    i_rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", int'(o_in_ready), 1);

    // three sets of 1.0
    fill_const(3 * NE, 8'h10);
    send_frame(1'b0);
    drain(0, 1'b0, -1);

    // ramp, +1.0, -1.0 sets
    beat_q.delete();
    for (int b = 0; b < NE; b++) beat_q.push_back(8'(b));
    for (int b = 0; b < NE; b++) beat_q.push_back(8'h10);
    for (int b = 0; b < NE; b++) beat_q.push_back(8'hF0);
    send_frame(1'b0);
    drain(0, 1'b0, -1);

    // saturation on the output path
    fill_const(3 * NE, 8'h7F);
    send_frame(1'b0);
    drain(0, 1'b0, -1);
    fill_const(3 * NE, 8'h80);
    send_frame(1'b0);
    drain(0, 1'b0, -1);

    // stall with clock-enable toggling, then a fresh frame
    fill_rand(3 * NE);
    send_frame(1'b1);
    drain(1, 1'b0, -1);
    fill_rand(2 * NE);
    send_frame(1'b0);
    drain(2, 1'b0, -1);

    // protocol errors: beat during drain, then early last
    fill_rand(3 * NE);
    send_frame(1'b0);
    drain(0, 1'b1, -1);
    fill_rand(5);
    send_frame(1'b0);
    drain(2, 1'b0, -1);

    // asynchronous reset mid-drain, then a single set
    fill_rand(3 * NE);
    send_frame(1'b0);
    drain(0, 1'b0, 3);
    fill_const(NE, 8'h20);
    send_frame(1'b0);
    drain(0, 1'b0, -1);

    for (int f = 0; f < 6; f++) begin
      fill_rand(NE * $urandom_range(1, 3));
      send_frame(1'b1);
      drain(2, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
